// File: rtl/mips_du_pkg.sv
// Shared debug-unit definitions: datapath image widths, frame constants and dump FSM states.
// Reused by the datapath, the UART top and the dump engine.
package mips_du_pkg;

   localparam int unsigned DU_REG_W         = 1024;
   localparam int unsigned DU_MEM_W         = 256;
   localparam int unsigned DU_IFID_W        = 64;
   localparam int unsigned DU_IDEX_W        = 126;
   localparam int unsigned DU_PAD_W         = 2;
   localparam int unsigned DU_SNAP_W        = DU_PAD_W + DU_IDEX_W + DU_IFID_W + DU_MEM_W
                                              + DU_REG_W;
   localparam int unsigned DU_PAYLOAD_BYTES = DU_SNAP_W / 8;
   localparam logic [7:0]  DU_HEADER        = 8'hA5;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StHeader   = 2'd1,
      StPayload  = 2'd2,
      StChecksum = 2'd3
   } du_state_e;

endpackage

// File: rtl/du_byte_sel.sv
// Snapshot register for the debug frame plus the index-to-byte payload mux.
// The image is captured only on i_load so later datapath activity cannot disturb a frame.
module du_byte_sel
   import mips_du_pkg::*;
#(
   parameter int unsigned PAYLOAD_BYTES = DU_PAYLOAD_BYTES
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_load,
   input  logic [PAYLOAD_BYTES*8-1:0]   i_snap,
   input  logic [7:0]                   i_idx,
   output logic [7:0]                   o_byte
);

   logic [PAYLOAD_BYTES*8-1:0] r_snap;
   logic [10:0]                w_ofs;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_snap <= '0;
      end else if (i_load) begin
         r_snap <= i_snap;
      end
   end

   always_comb begin
      w_ofs  = {i_idx, 3'b000};
      o_byte = r_snap[w_ofs +: 8];
   end

endmodule

// File: rtl/debug_dump.sv
// Debug dump engine: on a halt edge or manual request, streams HEADER, the latched datapath
// snapshot byte by byte, and an XOR checksum over a valid/ready byte interface.
module debug_dump
   import mips_du_pkg::*;
#(
   parameter logic [7:0]  HEADER        = DU_HEADER,
   parameter int unsigned PAYLOAD_BYTES = DU_PAYLOAD_BYTES
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DU_REG_W-1:0]    du_reg,
   input  logic [DU_MEM_W-1:0]    du_mem,
   input  logic [DU_IFID_W-1:0]   du_if_id,
   input  logic [DU_IDEX_W-1:0]   du_id_ex,
   input  logic                   du_halt,
   input  logic                   dump_req,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic                   busy,
   output logic                   done
);

   localparam logic [7:0] LastIdx = 8'(PAYLOAD_BYTES - 1);

   du_state_e            r_state, w_state_nxt;
   logic [7:0]           r_idx, w_idx_nxt;
   logic [7:0]           r_csum, w_csum_nxt;
   logic                 r_done, w_done_nxt;
   logic                 r_halt_prev;
   logic                 r_armed;
   logic                 w_halt_edge;
   logic                 w_trigger;
   logic                 w_xfer;
   logic [7:0]           w_byte;
   logic [DU_SNAP_W-1:0] w_snap;

   assign w_snap = {{DU_PAD_W{1'b0}}, du_id_ex, du_if_id, du_mem, du_reg};

   du_byte_sel #(
      .PAYLOAD_BYTES (PAYLOAD_BYTES)
   ) u_byte_sel (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_load  (w_trigger),
      .i_snap  (w_snap),
      .i_idx   (r_idx),
      .o_byte  (w_byte)
   );

   // r_armed stays low for the first cycle after reset so a halt already high is not an edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= StIdle;
         r_idx       <= '0;
         r_csum      <= '0;
         r_done      <= 1'b0;
         r_halt_prev <= 1'b0;
         r_armed     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_csum      <= w_csum_nxt;
         r_done      <= w_done_nxt;
         r_halt_prev <= du_halt;
         r_armed     <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_csum_nxt  = r_csum;
      w_done_nxt  = 1'b0;
      w_halt_edge = r_armed & du_halt & ~r_halt_prev;
      w_trigger   = (r_state == StIdle) & (w_halt_edge | dump_req);
      w_xfer      = (r_state != StIdle) & tx_ready;

      unique case (r_state)
         StIdle: begin
            if (w_trigger) begin
               w_state_nxt = StHeader;
               w_idx_nxt   = '0;
               w_csum_nxt  = '0;
            end
         end
         StHeader: begin
            if (w_xfer) w_state_nxt = StPayload;
         end
         StPayload: begin
            if (w_xfer) begin
               w_csum_nxt = r_csum ^ w_byte;
               if (r_idx == LastIdx) begin
                  w_state_nxt = StChecksum;
               end else begin
                  w_idx_nxt = r_idx + 8'd1;
               end
            end
         end
         StChecksum: begin
            if (w_xfer) begin
               w_state_nxt = StIdle;
               w_done_nxt  = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      tx_valid = (r_state != StIdle);
      busy     = (r_state != StIdle);
      done     = r_done;
      tx_data  = 8'h00;
      unique case (r_state)
         StIdle:     tx_data = 8'h00;
         StHeader:   tx_data = HEADER;
         StPayload:  tx_data = w_byte;
         StChecksum: tx_data = r_csum;
      endcase
   end

endmodule

// File: tb/tb_debug_dump.sv
// Directed bench for debug_dump: frame content, checksum, timing, back-pressure, retrigger
// rules and mid-frame reset, against a snapshot model built from the bench's own inputs.
module tb_debug_dump;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [1023:0]   du_reg = '0;
   logic [255:0]    du_mem = '0;
   logic [63:0]     du_if_id = '0;
   logic [125:0]    du_id_ex = '0;
   logic            du_halt = 1'b0;
   logic            dump_req = 1'b0;
   logic            tx_ready = 1'b0;
   logic [7:0]      tx_data;
   logic            tx_valid;
   logic            busy;
   logic            done;

   debug_dump dut (
      .clk      (clk),
      .reset    (reset),
      .du_reg   (du_reg),
      .du_mem   (du_mem),
      .du_if_id (du_if_id),
      .du_id_ex (du_id_ex),
      .du_halt  (du_halt),
      .dump_req (dump_req),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Monitor: collects transferred bytes, done pulses and hold-stability violations.
   logic [7:0] rx_q[$];
   int         n_done = 0;
   int         done_cyc = 0;
   int         n_unstable = 0;
   logic       stall_q = 1'b0;
   logic [7:0] stall_data = 8'h00;

   always @(negedge clk) begin
      if (stall_q && reset && (!tx_valid || tx_data !== stall_data)) n_unstable <= n_unstable + 1;
      stall_q    <= tx_valid && !tx_ready && reset;
      stall_data <= tx_data;
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (done) begin
         n_done   <= n_done + 1;
         done_cyc <= cyc;
      end
   end

   // Ready driver: 1 = always ready, 2 = ready one cycle in three, phased from the trigger.
   int rdy_mode = 1;
   int trig_cyc = 0;
   always begin
      @(posedge clk);
      #1;
      tx_ready = (rdy_mode == 1) ||
                 (rdy_mode == 2 && cyc > trig_cyc && ((cyc - trig_cyc) % 3 == 0));
   end

   logic [1471:0] snap;
   logic [7:0]    exp_frame[186];
   logic [7:0]    t2_frame[186];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic build_exp();
      logic [7:0] cs;
      logic [7:0] b;
      snap = {2'b00, du_id_ex, du_if_id, du_mem, du_reg};
      exp_frame[0] = 8'hA5;
      cs = 8'h00;
      for (int k = 0; k < 184; k++) begin
         b = snap[8*k +: 8];
         exp_frame[k+1] = b;
         cs ^= b;
      end
      exp_frame[185] = cs;
   endtask

   task automatic wait_done(input string tag, input int bound);
      int start;
      int i;
      start = n_done;
      i = 0;
      while (n_done == start && i < bound) begin
         @(negedge clk);
         i++;
      end
      check(tag, 32'(n_done != start), 32'd1);
      tick(1);
   endtask

   task automatic check_frame(input string tag);
      int bad;
      bad = 0;
      check({tag, "_len"}, rx_q.size(), 32'd186);
      for (int i = 0; i < 186 && i < rx_q.size(); i++)
         if (rx_q[i] !== exp_frame[i]) bad++;
      check({tag, "_bytes_bad"}, bad, 32'd0);
   endtask

   task automatic wait_bytes(input string tag, input int n);
      int i;
      i = 0;
      while (rx_q.size() < n && i < 400) begin
         tick(1);
         i++;
      end
      check(tag, 32'(rx_q.size() >= n), 32'd1);
   endtask

   initial begin
      int start;
      tick(3);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      reset = 1'b1;
      tick(2);
      check("post_rst_busy", busy, 1'b0);

      // Register words equal their index, manual request.
      for (int i = 0; i < 32; i++) du_reg[32*i +: 32] = 32'(i);
      build_exp();
      rx_q.delete();
      dump_req = 1'b1;
      trig_cyc = cyc;
      tick(1);
      dump_req = 1'b0;
      check("t1_busy", busy, 1'b1);
      check("t1_hdr_data", tx_data, 8'hA5);
      wait_done("t1_done", 400);
      check_frame("t1");
      check("t1_byte5", rx_q[5], 8'h01);
      check("t1_byte125", rx_q[125], 8'h1F);
      check("t1_csum", rx_q[185], 8'h00);
      check("t1_done_lat", done_cyc - trig_cyc, 32'd187);
      check("t1_done_pulse", done, 1'b0);
      check("t1_busy_end", busy, 1'b0);

      // Memory all ones, halt rising edge.
      du_reg = '0;
      du_mem = '1;
      build_exp();
      rx_q.delete();
      du_halt = 1'b1;
      trig_cyc = cyc;
      wait_done("t2_done", 400);
      check_frame("t2");
      check("t2_byte128", rx_q[128], 8'h00);
      check("t2_byte129", rx_q[129], 8'hFF);
      check("t2_byte160", rx_q[160], 8'hFF);
      check("t2_byte161", rx_q[161], 8'h00);
      check("t2_csum", rx_q[185], 8'h00);
      check("t2_done_lat", done_cyc - trig_cyc, 32'd187);
      for (int i = 0; i < 186; i++) t2_frame[i] = exp_frame[i];
      rx_q.delete();
      tick(300);
      check("t2_no_retrigger", rx_q.size(), 32'd0);

      // Same image with back-pressure: ready one cycle in three.
      du_halt = 1'b0;
      tick(2);
      rx_q.delete();
      n_unstable = 0;
      rdy_mode = 2;
      du_halt = 1'b1;
      trig_cyc = cyc;
      wait_done("t3_done", 700);
      check_frame("t3");
      check("t3_same_as_t2", 32'(rx_q[129] == t2_frame[129] && rx_q[185] == t2_frame[185]),
            32'd1);
      check("t3_done_lat", done_cyc - trig_cyc, 32'd559);
      check("t3_unstable", n_unstable, 32'd0);
      rdy_mode = 1;
      du_halt = 1'b0;
      tick(2);

      // Inputs change mid-frame and a request arrives at byte 50.
      for (int i = 0; i < 32; i++) du_reg[32*i +: 32] = 32'hDEAD_0000 + 32'(i * 7);
      du_mem   = {8{32'hC0FF_EE11}};
      du_if_id = 64'h0123_4567_89AB_CDEF;
      du_id_ex = {62'h2BAD_F00D_1234_5678, 64'h0F0F_F0F0_A5A5_5A5A};
      build_exp();
      rx_q.delete();
      start = n_done;
      dump_req = 1'b1;
      trig_cyc = cyc;
      tick(1);
      dump_req = 1'b0;
      wait_bytes("t4_reach50", 50);
      du_reg   = ~du_reg;
      du_mem   = '0;
      du_if_id = ~du_if_id;
      du_id_ex = ~du_id_ex;
      du_halt  = 1'b1;
      dump_req = 1'b1;
      tick(1);
      dump_req = 1'b0;
      wait_done("t4_done", 400);
      check_frame("t4");
      check("t4_done_lat", done_cyc - trig_cyc, 32'd187);
      tick(250);
      check("t4_one_frame", n_done - start, 32'd1);
      check("t4_no_extra", rx_q.size(), 32'd186);
      du_halt = 1'b0;
      tick(2);

      // Reset mid-frame, then halt already high at release.
      build_exp();
      rx_q.delete();
      dump_req = 1'b1;
      tick(1);
      dump_req = 1'b0;
      wait_bytes("t5_reach100", 100);
      #2;
      reset = 1'b0;
      #1;
      check("t5_rst_valid", tx_valid, 1'b0);
      check("t5_rst_busy", busy, 1'b0);
      check("t5_rst_data", tx_data, 8'h00);
      du_halt = 1'b1;
      tick(2);
      reset = 1'b1;
      rx_q.delete();
      tick(300);
      check("t5_no_frame", rx_q.size(), 32'd0);
      check("t5_idle_valid", tx_valid, 1'b0);
      du_halt = 1'b0;
      tick(1);
      du_halt = 1'b1;
      trig_cyc = cyc;
      wait_done("t5_done", 400);
      check_frame("t5");
      check("t5_done_lat", done_cyc - trig_cyc, 32'd187);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/debug_dump.md
DEBUG_DUMP -- requirements
Module: debug_dump

Interface
REQ-001 Parameter HEADER, default 8'hA5: frame start byte.
REQ-002 Parameter PAYLOAD_BYTES, default 184: snapshot bytes per frame, fixed by the du_* widths.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 du_reg  input  1024  register file image, reg0 in bits [31:0].
REQ-006 du_mem  input  256  data memory image.
REQ-007 du_if_id  input  64  IF/ID latch image.
REQ-008 du_id_ex  input  126  ID/EX latch image.
REQ-009 du_halt  input  1  datapath halted.
REQ-010 dump_req  input  1  one-cycle manual dump request.
REQ-011 tx_data  output  8  byte to UART transmitter.
REQ-012 tx_valid  output  1  tx_data valid.
REQ-013 tx_ready  input  1  transmitter accepts byte.
REQ-014 busy  output  1  frame in progress.
REQ-015 done  output  1  one-cycle pulse after last byte accepted.

Function
REQ-016 Trigger = rising edge of du_halt (registered compare) or dump_req high, only in IDLE; triggers outside IDLE are dropped.
REQ-017 On trigger, 1472-bit snapshot = {2'b00, du_id_ex, du_if_id, du_mem, du_reg} is latched in the same cycle; later input changes do not affect the frame.
REQ-018 Payload byte k (0..183) = snapshot[8k+7:8k]; byte 0 = du_reg[7:0].
REQ-019 Frame = HEADER, payload bytes 0..183, checksum = XOR of all 184 payload bytes; 186 bytes total.
REQ-020 FSM states IDLE -> HEADER -> PAYLOAD -> CHECKSUM -> IDLE; transitions out of HEADER/CHECKSUM and payload index increments occur only on a transfer (tx_valid & tx_ready).
REQ-021 tx_valid asserted in HEADER, PAYLOAD, CHECKSUM; tx_data and tx_valid held stable until transfer; tx_valid never depends combinationally on tx_ready.
REQ-022 First tx_valid one cycle after trigger cycle; with tx_ready constantly high, one byte per cycle, done pulses in the cycle after the checksum transfer, 187 cycles after trigger.
REQ-023 PAYLOAD exits after transfer of index 183 (8-bit index, no wrap past 183).
REQ-024 Checksum accumulator cleared at trigger, updated on each payload transfer.
REQ-025 busy high from cycle after trigger until done cycle inclusive-exclusive: high in HEADER/PAYLOAD/CHECKSUM only.
REQ-026 du_halt held high after a dump does not retrigger; re-arm requires du_halt low for at least one cycle.
REQ-027 dump_req coinciding with halt edge produces exactly one frame.

Reset
REQ-028 reset low: state IDLE, tx_valid 0, tx_data 8'h00, busy 0, done 0, index 0, checksum 0, halt edge register 0; asserting mid-frame aborts immediately, no resume.
REQ-029 du_halt already high at reset release does not trigger (edge register reset to 0 counts as edge: excluded by sampling du_halt into edge register on first cycle before enabling triggers).

Structure
REQ-030 Shared package mips_du_pkg holds DU widths (1024/256/64/126), HEADER, PAYLOAD_BYTES and FSM state encodings; reused by DataPath and UART top.
REQ-031 One sub-module du_byte_sel: snapshot register plus index-to-byte mux, 184:1 of 8 bits.

Verification
REQ-032 du_reg = word i equal i (i=0..31), others 0, dump_req pulse, tx_ready=1 -> bytes A5, 00,00,00,00, 01,00,00,00, ...; checksum 8'h00 (word pairs cancel except as computed: bench compares to model XOR).
REQ-033 du_mem all 8'hFF, rest 0, du_halt 0->1 -> frame with 32 bytes FF at indices 128..159, checksum 8'h00, done at cycle 187.
REQ-034 tx_ready toggling 1-of-3 cycles -> byte stream identical to REQ-033, tx_data stable while tx_valid & !tx_ready, 558-cycle frame.
REQ-035 Change all du_* inputs mid-frame and pulse dump_req at byte 50 -> frame unchanged, no second frame.
REQ-036 reset low at byte 100 -> tx_valid 0 immediately; after release, du_halt held high -> no frame; du_halt low then high -> full 186-byte frame.
